// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command engine: opcodes, status codes,
// FSM states and the 64-bit command/response word layout.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_PING  = 8'h03;

    localparam logic [7:0] ST_OK         = 8'h00;
    localparam logic [7:0] ST_BAD_OPCODE = 8'h01;
    localparam logic [7:0] ST_TIMEOUT    = 8'h02;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // code is the opcode in a command and the status in a response
    typedef struct packed {
        logic [7:0]  code;
        logic [7:0]  tag;
        logic [15:0] addr;
        logic [31:0] data;
    } cmd_word_t;

endpackage

// File: rtl/uart_cmd_engine.sv
// Executes 64-bit host commands as register-bus reads/writes/pings and
// returns one 64-bit response per command; one command in flight at a time.
module uart_cmd_engine
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [15:0]      reg_addr,
    output logic [31:0]      reg_wdata,
    output logic             reg_wr,
    output logic             reg_rd,
    input  logic [31:0]      reg_rdata,
    input  logic             reg_ack,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    cmd_word_t        cmd_in, cmd_reg, resp_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [15:0]      reg_addr_reg;
    logic [31:0]      reg_wdata_reg;
    logic [CNT_W-1:0] cmd_count_reg, err_count_reg;
    logic             cmd_fire, resp_fire, op_bus, timer_done;

    assign cmd_in     = s_axis_tdata;
    assign cmd_fire   = s_axis_tvalid && s_axis_tready;
    assign resp_fire  = m_axis_tvalid && m_axis_tready;
    assign op_bus     = (cmd_in.code == OP_WRITE) || (cmd_in.code == OP_READ);
    assign timer_done = (timer_reg == TMR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_fire) state_next = op_bus ? BUS : RESP;
            BUS:     if (reg_ack || timer_done) state_next = RESP;
            RESP:    if (m_axis_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and strobe outputs decode the state directly so reset kills them at once
    always_comb begin
        s_axis_tready = (state_reg == IDLE);
        m_axis_tvalid = (state_reg == RESP);
        busy          = (state_reg != IDLE);
        reg_wr        = (state_reg == BUS) && (cmd_reg.code == OP_WRITE);
        reg_rd        = (state_reg == BUS) && (cmd_reg.code == OP_READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg       <= '0;
            resp_reg      <= '0;
            timer_reg     <= '0;
            reg_addr_reg  <= '0;
            reg_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_fire) begin
                        cmd_reg   <= cmd_in;
                        timer_reg <= '0;
                        if (op_bus) begin
                            reg_addr_reg  <= cmd_in.addr;
                            reg_wdata_reg <= cmd_in.data;
                        end else if (cmd_in.code == OP_PING) begin
                            resp_reg <= '{ST_OK, cmd_in.tag, cmd_in.addr, cmd_in.data};
                        end else begin
                            resp_reg <= '{ST_BAD_OPCODE, cmd_in.tag, cmd_in.addr, 32'h0};
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a simultaneous timeout
                    if (reg_ack) begin
                        resp_reg <= '{ST_OK, cmd_reg.tag, cmd_reg.addr,
                                      (cmd_reg.code == OP_READ) ? reg_rdata : cmd_reg.data};
                    end else if (timer_done) begin
                        resp_reg <= '{ST_TIMEOUT, cmd_reg.tag, cmd_reg.addr, 32'h0};
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count_reg <= '0;
            err_count_reg <= '0;
        end else begin
            if (cmd_fire && !(&cmd_count_reg))
                cmd_count_reg <= cmd_count_reg + 1'b1;
            if (resp_fire && (resp_reg.code != ST_OK) && !(&err_count_reg))
                err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign m_axis_tdata = resp_reg;
    assign reg_addr     = reg_addr_reg;
    assign reg_wdata    = reg_wdata_reg;
    assign cmd_count    = cmd_count_reg;
    assign err_count    = err_count_reg;

endmodule

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
- Command processor sitting directly downstream of the 64-bit UART word adapter.
- Consumes each received 64-bit command word and executes it as a register-bus read, write or ping.
- Returns one 64-bit response word per command, which feeds back into the adapter's transmit input.
- Gives a host PC register-level access to the design over the serial link.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a bus strobe is held waiting for reg_ack; must be >= 1.
- CNT_W, 16: width of the saturating command/error counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  64  command word (from UART adapter output)
- s_axis_tvalid  in  1  command valid
- s_axis_tready  out  1  engine accepts command
- m_axis_tdata  out  64  response word (to UART adapter input)
- m_axis_tvalid  out  1  response valid
- m_axis_tready  in  1  response accepted
- reg_addr  out  16  register address
- reg_wdata  out  32  write data
- reg_wr  out  1  write strobe, held until ack/timeout
- reg_rd  out  1  read strobe, held until ack/timeout
- reg_rdata  in  32  read data, valid when reg_ack=1
- reg_ack  in  1  bus completion
- busy  out  1  high whenever state != IDLE
- cmd_count  out  CNT_W  commands accepted, saturating
- err_count  out  CNT_W  error responses issued, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; s_axis_tready=1; m_axis_tvalid=0; m_axis_tdata=0; reg_wr=reg_rd=0; reg_addr=0; reg_wdata=0; counters=0; busy=0.
- Reset mid-operation: strobes and m_axis_tvalid drop immediately (asynchronously). The in-flight command is discarded and no response is sent.
- Command fields:
  - [63:56] opcode
  - [55:48] tag
  - [47:32] addr
  - [31:0] data
- Opcodes: 0x01 WRITE, 0x02 READ, 0x03 PING. Any other value is illegal.
- Response fields:
  - [63:56] status: 0x00 OK, 0x01 BAD_OPCODE, 0x02 TIMEOUT
  - [55:48] tag, echoed
  - [47:32] addr, echoed
  - [31:0] data:
    - READ OK: reg_rdata
    - WRITE OK: command data
    - PING: command data
    - BAD_OPCODE or TIMEOUT: 0
- States: IDLE, BUS, RESP.
- IDLE:
  - s_axis_tready=1.
  - On tvalid&&tready: capture the word and increment cmd_count.
  - WRITE/READ -> BUS; load reg_addr/reg_wdata and clear the timeout counter.
  - PING -> RESP, status OK.
  - Illegal opcode -> RESP, status BAD_OPCODE.
- BUS:
  - s_axis_tready=0; reg_wr (WRITE) or reg_rd (READ) held high.
  - reg_ack sampled high -> strobe low next cycle; form response (capture reg_rdata for READ); -> RESP.
  - No ack after TIMEOUT_CYCLES cycles in BUS -> strobe low; status TIMEOUT; -> RESP.
  - If ack arrives in the same cycle the timeout expires, ack wins and status is OK.
- RESP:
  - m_axis_tvalid=1; m_axis_tdata stable until handshake.
  - On m_axis_tready -> IDLE, and tvalid low the next cycle.
  - A response with status != OK increments err_count on its handshake.
- reg_ack outside BUS is ignored.
- Counters saturate at all-ones; they never wrap.
- Latency:
  - WRITE/READ with immediate ack: handshake at cycle 0; strobe at cycle 1; tvalid at cycle 2.
  - PING or illegal opcode: tvalid at cycle 1.
- Throughput: at most one outstanding command; no command is accepted until the response handshake completes.

Decomposition:
- Package uart_cmd_pkg holds:
  - the opcode and status localparams;
  - the state enum typedef;
  - a packed struct typedef for the command/response word layout (opcode/status, tag, addr, data).
- Single module; no sub-module is warranted. The timeout counter is an inline counter in BUS.

Test Plan:
- WRITE: cmd 0x01_5A_0010_DEADBEEF, ack on the first strobe cycle -> reg_wr high for one cycle with addr 0x0010, wdata 0xDEADBEEF; response 0x00_5A_0010_DEADBEEF at cycle 2; cmd_count=1.
- READ: cmd 0x02_07_0004_00000000, ack after 5 cycles with rdata 0x12345678 -> reg_rd high for exactly 5 cycles; response 0x00_07_0004_12345678.
- Timeout: READ with no ack, TIMEOUT_CYCLES=8 -> reg_rd high for 8 cycles then low; response 0x02_tag_addr_00000000; err_count=1.
- Illegal opcode and PING: 0x7F_01_0000_00000001 -> response 0x01_01_0000_00000000 at cycle 1. PING 0x03_02_ABCD_CAFEF00D -> identical echo apart from status 0x00.
- Backpressure/reset: hold m_axis_tready=0 for 20 cycles -> tvalid and data stable and s_axis_tready=0 throughout. Assert rst_n low mid-BUS -> strobe and tvalid drop immediately, counters clear, next command processes normally.
